// File: rtl/time_entry.sv
// Keypad time-entry stage: buffers up to four digits, validates them as HH:MM
// on SET and hands the result to the time counter with a one-cycle load strobe.
module time_entry #(
    parameter int TIMEOUT_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] new_current_time_ms_hr,
    output logic [3:0] new_current_time_ls_hr,
    output logic [3:0] new_current_time_ms_min,
    output logic [3:0] new_current_time_ls_min,
    output logic       load_new_c,
    output logic       entry_active,
    output logic       entry_error,
    output logic       entry_timeout,
    output logic [2:0] key_count
);

    localparam int TW = $clog2(TIMEOUT_SECS + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_SECS);

    typedef enum logic {IDLE, ENTRY} state_t;

    state_t             state, state_nxt;
    logic [3:0][3:0]    buf_q, buf_nxt;      // [3] = ms_hr ... [0] = ls_min
    logic [3:0][3:0]    time_q, time_nxt;
    logic [2:0]         count_q, count_nxt;
    logic [TW-1:0]      timer_q, timer_nxt;
    logic               load_nxt, error_nxt, timeout_nxt;

    logic is_digit, is_set, is_clear, time_ok;

    assign is_digit = key_valid && (key <= 4'd9);
    assign is_set   = key_valid && (key == 4'hA);
    assign is_clear = key_valid && (key == 4'hB);

    // Unentered upper digits are already zero, so short entries validate naturally.
    assign time_ok = (buf_q[3] <= 4'd2)
                  && !((buf_q[3] == 4'd2) && (buf_q[2] > 4'd3))
                  && (buf_q[1] <= 4'd5);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt   = state;
        buf_nxt     = buf_q;
        time_nxt    = time_q;
        count_nxt   = count_q;
        timer_nxt   = timer_q;
        load_nxt    = 1'b0;
        error_nxt   = 1'b0;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (is_digit) begin
                    buf_nxt    = '0;
                    buf_nxt[0] = key;
                    count_nxt  = 3'd1;
                    timer_nxt  = '0;
                    state_nxt  = ENTRY;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    buf_nxt   = {buf_q[2:0], key};
                    count_nxt = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
                    timer_nxt = '0;
                end else if (is_clear) begin
                    buf_nxt   = '0;
                    count_nxt = '0;
                    timer_nxt = '0;
                end else if (is_set) begin
                    if (time_ok) begin
                        time_nxt = buf_q;
                        load_nxt = 1'b1;
                    end else begin
                        error_nxt = 1'b1;
                    end
                    buf_nxt   = '0;
                    count_nxt = '0;
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else if (one_second) begin
                    // An accepted key in the same cycle takes priority over the tick.
                    if (timer_q + TW'(1) == LIMIT) begin
                        timeout_nxt = 1'b1;
                        buf_nxt     = '0;
                        count_nxt   = '0;
                        timer_nxt   = '0;
                        state_nxt   = IDLE;
                    end else begin
                        timer_nxt = timer_q + TW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            buf_q         <= '0;
            time_q        <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            load_new_c    <= 1'b0;
            entry_error   <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            state         <= state_nxt;
            buf_q         <= buf_nxt;
            time_q        <= time_nxt;
            count_q       <= count_nxt;
            timer_q       <= timer_nxt;
            load_new_c    <= load_nxt;
            entry_error   <= error_nxt;
            entry_timeout <= timeout_nxt;
        end
    end

    assign new_current_time_ms_hr  = time_q[3];
    assign new_current_time_ls_hr  = time_q[2];
    assign new_current_time_ms_min = time_q[1];
    assign new_current_time_ls_min = time_q[0];
    assign entry_active            = (state == ENTRY);
    assign key_count               = count_q;

endmodule
